// File: rtl/envelope_dynamics_pkg.sv
// Shared types and constants for the envelope_dynamics block.
package envelope_dynamics_pkg;

    // Envelope phases; encodings are visible on env_state.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } env_state_t;

    // Gain of 1.0 in Q1.(gain_w-1).
    function automatic int unity(input int gain_w);
        return 1 << (gain_w - 1);
    endfunction

    // Half an output LSB after the Q1.(gain_w-1) shift; added before the
    // arithmetic shift to round half up.
    function automatic int half_lsb(input int gain_w);
        return 1 << (gain_w - 2);
    endfunction

endpackage

// File: rtl/envelope_dynamics_if.sv
// Sample stream, note events, envelope settings and status of envelope_dynamics.
// master drives samples/controls, slave is the envelope block.
interface envelope_dynamics_if #(
    parameter int SAMPLE_W = 16,
    parameter int GAIN_W   = 8,
    parameter int DIV_W    = 8
);
    logic                       in_valid;
    logic signed [SAMPLE_W-1:0] in_sample;
    logic                       note_on;
    logic                       note_off;
    logic [DIV_W-1:0]           tick_div;
    logic [GAIN_W-1:0]          attack_step;
    logic [GAIN_W-1:0]          decay_step;
    logic [GAIN_W-1:0]          release_step;
    logic [GAIN_W-1:0]          sustain_level;
    logic                       out_valid;
    logic signed [SAMPLE_W-1:0] out_sample;
    logic [GAIN_W-1:0]          env_gain;
    logic [2:0]                 env_state;
    logic                       busy;

    modport master (
        output in_valid, in_sample, note_on, note_off, tick_div,
               attack_step, decay_step, release_step, sustain_level,
        input  out_valid, out_sample, env_gain, env_state, busy
    );

    modport slave (
        input  in_valid, in_sample, note_on, note_off, tick_div,
               attack_step, decay_step, release_step, sustain_level,
        output out_valid, out_sample, env_gain, env_state, busy
    );
endinterface

// File: rtl/envelope_dynamics_gain_mul.sv
// gain_mul: two-stage signed sample x unsigned Q1.(GAIN_W-1) gain with
// round-half-up shift back to SAMPLE_W. Stage 1 captures the operands,
// stage 2 holds the rounded product. The result never exceeds SAMPLE_W
// because gain <= 1.0, so no saturation is applied.
module gain_mul
    import envelope_dynamics_pkg::*;
#(
    parameter int SAMPLE_W = 16,
    parameter int GAIN_W   = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_valid,
    input  logic signed [SAMPLE_W-1:0] i_sample,
    input  logic [GAIN_W-1:0]          i_gain,
    output logic                       o_valid,
    output logic signed [SAMPLE_W-1:0] o_sample
);
    localparam int PROD_W = SAMPLE_W + GAIN_W + 1;
    localparam logic signed [PROD_W-1:0] HALF = PROD_W'(half_lsb(GAIN_W));

    logic                       r_s1_valid;
    logic signed [SAMPLE_W-1:0] r_s1_sample;
    logic [GAIN_W-1:0]          r_s1_gain;
    logic                       r_s2_valid;
    logic signed [SAMPLE_W-1:0] r_s2_sample;

    logic signed [PROD_W-1:0]   w_sample_ext;
    logic signed [PROD_W-1:0]   w_gain_ext;
    logic signed [PROD_W-1:0]   w_rounded;

    // Gain is zero-extended so it multiplies as a non-negative value.
    assign w_sample_ext = {{(GAIN_W + 1){r_s1_sample[SAMPLE_W-1]}}, r_s1_sample};
    assign w_gain_ext   = {{(SAMPLE_W + 1){1'b0}}, r_s1_gain};
    assign w_rounded    = (w_sample_ext * w_gain_ext) + HALF;

    // Stage 1: capture operands; stage 2: capture rounded, shifted product.
    // NOTE: non-blocking assignments here so both stages read the values from
    // before this edge; blocking would collapse the pipeline into one stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_sample <= '0;
            r_s1_gain   <= '0;
            r_s2_valid  <= 1'b0;
            r_s2_sample <= '0;
        end else begin
            r_s1_valid  <= i_valid;
            r_s1_sample <= i_sample;
            r_s1_gain   <= i_gain;
            r_s2_valid  <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_sample <= SAMPLE_W'(w_rounded >>> (GAIN_W - 1));
            end
        end
    end

    assign o_valid  = r_s2_valid;
    assign o_sample = r_s2_sample;

endmodule

// File: rtl/envelope_dynamics.sv
// envelope_dynamics: ADSR gain envelope applied to a signed sample stream.
// Holds the sample-strobe tick divider, the envelope FSM and the gain
// register; scaling is done in gain_mul with a 2-cycle latency.
// Optional feature macro: ENVELOPE_LEGATO_EN (note_on while sounding
// re-attacks from the current gain without clearing the tick divider).
module envelope_dynamics
    import envelope_dynamics_pkg::*;
#(
    parameter int SAMPLE_W = 16,
    parameter int GAIN_W   = 8,
    parameter int DIV_W    = 8
) (
    input  logic                clk,
    input  logic                rst,
    envelope_dynamics_if.slave  bus
);
    localparam logic [GAIN_W-1:0] UNITY_G = GAIN_W'(unity(GAIN_W));

    env_state_t        r_state;
    logic [GAIN_W-1:0] r_gain;
    logic [DIV_W-1:0]  r_cnt;

    env_state_t        w_state_nxt;
    logic [GAIN_W-1:0] w_gain_nxt;
    logic [DIV_W-1:0]  w_cnt_nxt;
    logic              w_tick;
    logic [GAIN_W-1:0] w_sus;
    logic [GAIN_W:0]   w_att_sum;
    logic [GAIN_W:0]   w_dec_diff;
    logic [GAIN_W:0]   w_rel_diff;

    // One extra bit on sum/difference exposes overflow past UNITY or a borrow.
    assign w_tick     = bus.in_valid && (r_cnt == bus.tick_div);
    assign w_sus      = (bus.sustain_level > UNITY_G) ? UNITY_G : bus.sustain_level;
    assign w_att_sum  = {1'b0, r_gain} + {1'b0, bus.attack_step};
    assign w_dec_diff = {1'b0, r_gain} - {1'b0, bus.decay_step};
    assign w_rel_diff = {1'b0, r_gain} - {1'b0, bus.release_step};

    // Envelope state, gain and tick divider registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_gain  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_gain  <= w_gain_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next state/gain: note events take priority over the tick update.
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_gain_nxt  = r_gain;
        w_cnt_nxt   = r_cnt;
        if (bus.in_valid) begin
            w_cnt_nxt = w_tick ? '0 : r_cnt + DIV_W'(1);
        end

        if (bus.note_on) begin
            w_state_nxt = ST_ATTACK;
`ifdef ENVELOPE_LEGATO_EN
            if (r_state == ST_IDLE) begin
                w_gain_nxt = '0;
                w_cnt_nxt  = '0;
            end
`else
            w_gain_nxt = '0;
            w_cnt_nxt  = '0;
`endif
        end else if (bus.note_off &&
                     (r_state inside {ST_ATTACK, ST_DECAY, ST_SUSTAIN})) begin
            w_state_nxt = ST_RELEASE;
        end else if (w_tick) begin
            case (r_state)
                ST_ATTACK: begin
                    if (bus.attack_step == '0 || w_att_sum >= {1'b0, UNITY_G}) begin
                        w_gain_nxt  = UNITY_G;
                        w_state_nxt = ST_DECAY;
                    end else begin
                        w_gain_nxt = w_att_sum[GAIN_W-1:0];
                    end
                end
                ST_DECAY: begin
                    if (bus.decay_step == '0 || w_dec_diff[GAIN_W] ||
                        w_dec_diff[GAIN_W-1:0] <= w_sus) begin
                        w_gain_nxt  = w_sus;
                        w_state_nxt = ST_SUSTAIN;
                    end else begin
                        w_gain_nxt = w_dec_diff[GAIN_W-1:0];
                    end
                end
                ST_RELEASE: begin
                    if (bus.release_step == '0 || w_rel_diff[GAIN_W] ||
                        w_rel_diff[GAIN_W-1:0] == '0) begin
                        w_gain_nxt  = '0;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_gain_nxt = w_rel_diff[GAIN_W-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    gain_mul #(
        .SAMPLE_W (SAMPLE_W),
        .GAIN_W   (GAIN_W)
    ) u_gain_mul (
        .clk      (clk),
        .rst      (rst),
        .i_valid  (bus.in_valid),
        .i_sample (bus.in_sample),
        .i_gain   (r_gain),
        .o_valid  (bus.out_valid),
        .o_sample (bus.out_sample)
    );

    assign bus.env_gain  = r_gain;
    assign bus.env_state = r_state;
    assign bus.busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_envelope_dynamics.sv
// Testbench for envelope_dynamics: directed scenarios with literal
// expectations plus randomized traffic against an ADSR reference model.
module tb_envelope_dynamics;
    localparam int SW   = 16;
    localparam int GW   = 8;
    localparam int DW   = 8;
    localparam int U    = 1 << (GW - 1);
    localparam int HALF = 1 << (GW - 2);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    envelope_dynamics_if #(.SAMPLE_W(SW), .GAIN_W(GW), .DIV_W(DW)) bus ();

    envelope_dynamics #(.SAMPLE_W(SW), .GAIN_W(GW), .DIV_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: phase number, gain, sample count since last tick,
    // and a two-deep delay line of expected output beats.
    int m_state, m_gain, m_cnt;
    int m_s1_v, m_s1_out, m_out_v, m_out;

    int exp_g [8] = '{32, 64, 96, 128, 80, 64, 64, 64};
    int exp_o [8] = '{0, 0, 4096, 8192, 12288, 16384, 10240, 8192};

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Round-half-up of s*g/UNITY using floor division.
    function automatic int scale(input int s, input int g);
        int p, q;
        p = s * g + HALF;
        q = p / U;
        if (p < 0 && (p % U) != 0) q = q - 1;
        return q;
    endfunction

    task automatic model_step();
        int tick, sus, ti_div;
        if (rst) begin
            m_state = 0; m_gain = 0; m_cnt = 0;
            m_s1_v = 0; m_s1_out = 0; m_out_v = 0; m_out = 0;
            return;
        end
        m_out_v = m_s1_v;
        if (m_s1_v != 0) m_out = m_s1_out;
        m_s1_v = int'(bus.in_valid);
        if (bus.in_valid) m_s1_out = scale(int'($signed(bus.in_sample)), m_gain);

        ti_div = int'(bus.tick_div);
        tick = (bus.in_valid && m_cnt == ti_div) ? 1 : 0;
        if (bus.in_valid) m_cnt = (tick != 0) ? 0 : (m_cnt + 1) % (1 << DW);
        sus = (int'(bus.sustain_level) > U) ? U : int'(bus.sustain_level);

        if (bus.note_on) begin
`ifdef ENVELOPE_LEGATO_EN
            if (m_state == 0) begin m_gain = 0; m_cnt = 0; end
`else
            m_gain = 0; m_cnt = 0;
`endif
            m_state = 1;
        end else if (bus.note_off && m_state >= 1 && m_state <= 3) begin
            m_state = 4;
        end else if (tick != 0) begin
            if (m_state == 1) begin
                m_gain = (bus.attack_step == 0) ? U : m_gain + int'(bus.attack_step);
                if (m_gain >= U) begin m_gain = U; m_state = 2; end
            end else if (m_state == 2) begin
                m_gain = (bus.decay_step == 0) ? sus : m_gain - int'(bus.decay_step);
                if (m_gain <= sus) begin m_gain = sus; m_state = 3; end
            end else if (m_state == 4) begin
                m_gain = (bus.release_step == 0) ? 0 : m_gain - int'(bus.release_step);
                if (m_gain <= 0) begin m_gain = 0; m_state = 0; end
            end
        end
    endtask

    // One clock: drive inputs, advance model on the edge, compare #1 later.
    task automatic cycle(input bit v, input int s, input bit on, input bit off);
        logic [31:0] sv;
        sv = s;
        bus.in_valid  = v;
        bus.in_sample = sv[SW-1:0];
        bus.note_on   = on;
        bus.note_off  = off;
        @(posedge clk);
        model_step();
        #1;
        check("out_valid",  int'(bus.out_valid), m_out_v);
        check("out_sample", int'($signed(bus.out_sample)), m_out);
        check("env_gain",   int'(bus.env_gain), m_gain);
        check("env_state",  int'(bus.env_state), m_state);
        check("busy",       int'(bus.busy), (m_state != 0) ? 1 : 0);
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.in_sample = '0;
        bus.note_on = 1'b0; bus.note_off = 1'b0;
        bus.tick_div = '0; bus.attack_step = 8'd32; bus.decay_step = 8'd48;
        bus.release_step = 8'd0; bus.sustain_level = 8'd64;

        rst = 1'b1;
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        rst = 1'b0;
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_out_sample", int'(bus.out_sample), 0);
        check("rst_env_gain", int'(bus.env_gain), 0);
        check("rst_env_state", int'(bus.env_state), 0);
        check("rst_busy", int'(bus.busy), 0);

        // Silence in IDLE, 2-cycle latency.
        cycle(1, 16'h4000, 0, 0);
        check("idle_lat1_valid", int'(bus.out_valid), 0);
        cycle(0, 0, 0, 0);
        check("idle_lat2_valid", int'(bus.out_valid), 1);
        check("idle_silence", int'(bus.out_sample), 0);
        check("idle_busy", int'(bus.busy), 0);

        // Attack 32/tick, decay 48 down to sustain 64.
        cycle(0, 0, 1, 0);
        for (int k = 0; k < 8; k++) begin
            cycle(1, 16'h4000, 0, 0);
            check("ad_gain", int'(bus.env_gain), exp_g[k]);
            if (k >= 1) check("ad_out", int'($signed(bus.out_sample)), exp_o[k]);
            if (k == 3) check("ad_to_decay", int'(bus.env_state), 2);
            if (k == 5) check("ad_to_sustain", int'(bus.env_state), 3);
        end
        for (int k = 0; k < 10; k++) cycle(1, 16'h4000, 0, 0);
        check("sustain_hold_gain", int'(bus.env_gain), 64);
        check("sustain_hold_state", int'(bus.env_state), 3);

        // Rounding at gain 64: -3 * 0.5 = -1.5 -> -1.
        cycle(1, -3, 0, 0);
        cycle(0, 0, 0, 0);
        check("round_neg_half", int'($signed(bus.out_sample)), -1);

        // Release with step 0 jumps to silence on the next tick.
        cycle(0, 0, 0, 1);
        check("rel_state", int'(bus.env_state), 4);
        check("rel_gain_held", int'(bus.env_gain), 64);
        cycle(1, 0, 0, 0);
        check("rel_gain_zero", int'(bus.env_gain), 0);
        check("rel_idle", int'(bus.env_state), 0);
        check("rel_busy", int'(bus.busy), 0);

        // Unity gain passes the most negative sample unchanged.
        bus.attack_step = 8'd0;
        cycle(0, 0, 1, 0);
        cycle(1, 0, 0, 0);
        cycle(1, -32768, 0, 0);
        cycle(0, 0, 0, 0);
        check("unity_min", int'($signed(bus.out_sample)), -32768);

        // Gain 1 on sample 64: exactly half an LSB rounds up to 1.
        bus.attack_step = 8'd1;
        cycle(0, 0, 1, 0);
        cycle(1, 0, 0, 0);
        cycle(1, 64, 0, 0);
        cycle(0, 0, 0, 0);
        check("round_half_up", int'($signed(bus.out_sample)), 1);

        // note_on with note_off from SUSTAIN 64.
        bus.attack_step = 8'd64; bus.decay_step = 8'd0;
        cycle(0, 0, 1, 0);
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        check("pre_both_state", int'(bus.env_state), 3);
        cycle(0, 0, 1, 1);
        check("both_state", int'(bus.env_state), 1);
`ifdef ENVELOPE_LEGATO_EN
        check("both_gain", int'(bus.env_gain), 64);
`else
        check("both_gain", int'(bus.env_gain), 0);
`endif

        // Reset mid-stream flushes the pipeline.
        cycle(1, 1000, 0, 0);
        cycle(1, 2000, 0, 0);
        rst = 1'b1;
        cycle(1, 3000, 0, 0);
        check("mid_rst_valid", int'(bus.out_valid), 0);
        check("mid_rst_sample", int'(bus.out_sample), 0);
        check("mid_rst_gain", int'(bus.env_gain), 0);
        check("mid_rst_state", int'(bus.env_state), 0);
        rst = 1'b0;
        cycle(0, 0, 0, 0);
        check("post_rst_valid", int'(bus.out_valid), 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 2) begin
                bus.tick_div      = DW'($urandom_range(0, 3));
                bus.attack_step   = GW'($urandom_range(0, 40));
                bus.decay_step    = GW'($urandom_range(0, 40));
                bus.release_step  = GW'($urandom_range(0, 40));
                bus.sustain_level = GW'($urandom_range(0, 160));
            end
            rst = ($urandom_range(0, 999) < 3);
            cycle(($urandom_range(0, 9) < 8), int'($urandom),
                  ($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 3));
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
